// File: rtl/serial_link_pkg.sv
// Shared definitions for the "10010" frame-sync serial link.
// Used by the transmitter (serial_frame_tx, line_history) and by the
// detector side of the link.
//   state_t   : transmitter FSM states
//   PREAMBLE  : sync word sent at the start of every frame, MSB first
//   PRE_LEN   : preamble length in line bits
//   STUFF_PAT : 4-bit line history after which a stuffed 1 is forced
package serial_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GUARD
  } state_t;

  localparam logic [4:0] PREAMBLE  = 5'b10010;
  localparam int         PRE_LEN   = 5;
  localparam logic [3:0] STUFF_PAT = 4'b1001;

endpackage

// File: rtl/line_history.sv
// Shift register of the last four bits driven on the serial line.
// The newest bit (hist_reg[0]) is the registered line output itself.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset (clears history)
//   bit_in      : bit to be driven on the line at the next clock edge
//   peek_bit    : candidate payload bit, used to look one bit ahead
//   line        : registered line bit (current j)
//   stuff_match : history equals STUFF_PAT, next bit must be a stuffed 1
//   tail_match  : history shifted by peek_bit would equal STUFF_PAT
module line_history
  import serial_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic peek_bit,
  output logic line,
  output logic stuff_match,
  output logic tail_match
);

  logic [3:0] hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
    end else begin
      hist_reg <= {hist_reg[2:0], bit_in};
    end
  end

  assign line        = hist_reg[0];
  assign stuff_match = (hist_reg == STUFF_PAT);
  // Lets the transmitter decide, while sending the last payload bit,
  // whether a tail stuff bit must follow it.
  assign tail_match  = ({hist_reg[2:0], peek_bit} == STUFF_PAT);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter for the "10010" frame-sync link.
// Sends preamble 10010, then the payload MSB first with a stuffed 1
// after every 1001 in the line history, then GUARD zero bits.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-low reset (enters GUARD, line low)
//   data_in : payload word, captured on valid && ready
//   valid   : payload word available
//   ready   : block is idle and can accept a word
//   j       : registered serial line output
//   busy    : block is not idle
//   done    : one-cycle pulse when a frame finishes and the block idles
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GUARD  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  output logic              j,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int GRD_W = $clog2(GUARD);

  state_t              state_reg,     state_next;
  logic [DATA_W-1:0]   shift_reg,     shift_next;
  logic [CNT_W-1:0]    bit_cnt_reg,   bit_cnt_next;
  logic [2:0]          pre_cnt_reg,   pre_cnt_next;
  logic [GRD_W-1:0]    guard_cnt_reg, guard_cnt_next;
  logic                done_reg,      done_next;
  // Set while a real frame is in flight, so the guard run that follows
  // reset does not produce a done pulse.
  logic                framed_reg,    framed_next;

  logic                line_bit;
  logic                stuff_match;
  logic                tail_match;
  logic [2:0]          pre_idx;

  line_history u_hist (
    .clk         (clk),
    .rst         (rst),
    .bit_in      (line_bit),
    .peek_bit    (shift_reg[DATA_W-1]),
    .line        (j),
    .stuff_match (stuff_match),
    .tail_match  (tail_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_GUARD;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      pre_cnt_reg   <= '0;
      guard_cnt_reg <= '0;
      done_reg      <= 1'b0;
      framed_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      pre_cnt_reg   <= pre_cnt_next;
      guard_cnt_reg <= guard_cnt_next;
      done_reg      <= done_next;
      framed_reg    <= framed_next;
    end
  end

  assign pre_idx = 3'(PRE_LEN - 1) - pre_cnt_reg;

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    pre_cnt_next   = pre_cnt_reg;
    guard_cnt_next = guard_cnt_reg;
    done_next      = 1'b0;
    framed_next    = framed_reg;
    line_bit       = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (valid) begin
          shift_next   = data_in;
          line_bit     = PREAMBLE[PRE_LEN-1];
          pre_cnt_next = 3'd1;
          framed_next  = 1'b1;
          state_next   = S_PRE;
        end
      end
      S_PRE: begin
        line_bit     = PREAMBLE[pre_idx];
        pre_cnt_next = pre_cnt_reg + 3'd1;
        if (pre_cnt_reg == 3'(PRE_LEN - 1)) begin
          bit_cnt_next = '0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (stuff_match) begin
          // Stuffed 1; the payload bit index does not advance.
          line_bit = 1'b1;
          if (bit_cnt_reg == CNT_W'(DATA_W)) begin
            guard_cnt_next = '0;
            state_next     = S_GUARD;
          end
        end else begin
          line_bit     = shift_reg[DATA_W-1];
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          // Last payload bit: stay one more bit only if it completes 1001.
          if (bit_cnt_reg == CNT_W'(DATA_W - 1) && !tail_match) begin
            guard_cnt_next = '0;
            state_next     = S_GUARD;
          end
        end
      end
      S_GUARD: begin
        line_bit       = 1'b0;
        guard_cnt_next = guard_cnt_reg + 1'b1;
        if (guard_cnt_reg == GRD_W'(GUARD - 1)) begin
          guard_cnt_next = '0;
          done_next      = framed_reg;
          framed_next    = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: begin
        state_next = S_GUARD;
      end
    endcase
  end

  assign ready = (state_reg == S_IDLE);
  assign busy  = (state_reg != S_IDLE);
  assign done  = done_reg;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       j;
  logic       busy;
  logic       done;

  serial_frame_tx #(.DATA_W(8), .GUARD(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .j       (j),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic pre_end;
    logic last;
  } exp_t;

  exp_t       q[$];
  logic [3:0] mh;
  logic [4:0] det_sh = '0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         last_len = 0;
  int         det_count = 0;
  logic       accepted = 1'b0;
  logic       done_seen = 1'b0;
  logic       done_at_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_bit(input logic b, input logic pe, input logic last);
    exp_t e;
    e.b = b;
    e.pre_end = pe;
    e.last = last;
    q.push_back(e);
    mh = {mh[2:0], b};
  endtask

  // Reference encoder: preamble, payload with 1001-stuffing, tail stuff, guard.
  task automatic push_frame(input logic [7:0] w);
    logic [4:0] pre;
    pre = 5'b10010;
    mh = '0;
    for (int i = 4; i >= 0; i--) push_bit(pre[i], (i == 0), 1'b0);
    for (int i = 7; i >= 0; i--) begin
      if (mh == 4'b1001) push_bit(1'b1, 1'b0, 1'b0);
      push_bit(w[i], 1'b0, 1'b0);
    end
    if (mh == 4'b1001) push_bit(1'b1, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0, 1'b0);
    push_bit(1'b0, 1'b0, 1'b1);
  endtask

  // One clock: note any accept, advance, then compare the line bit.
  task automatic step();
    logic       acc;
    logic [7:0] w;
    logic       det;
    exp_t       e;
    acc = valid && ready && rst;
    w = data_in;
    if (acc) done_at_acc = done;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      push_frame(w);
      acc_cyc = cyc;
      accepted = 1'b1;
    end
    det_sh = {det_sh[3:0], j};
    det = (det_sh == 5'b10010);
    if (det) det_count++;
    if (done) begin
      last_len = cyc - acc_cyc + 1;
      done_seen = 1'b1;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check("j", j, e.b);
      check("sync_pos", det, e.pre_end);
      check("done", done, e.last);
      if (!e.last) check("busy", busy, 1);
    end else begin
      check("j_idle", j, 0);
      check("sync_idle", det, 0);
      check("done_idle", done, 0);
    end
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    data_in = w;
    valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 40) begin
      step();
      n++;
    end
    check("accept", accepted, 1);
  endtask

  task automatic wait_done(input logic [7:0] w, input int exp_len);
    int n;
    done_seen = 1'b0;
    n = 0;
    while (!done_seen && n < 100) begin
      step();
      n++;
    end
    check("done_seen", done_seen, 1);
    check("frame_len", last_len, exp_len);
    $display("frame word=%02h len=%0d", w, last_len);
  endtask

  task automatic release_chk();
    rst = 1'b1;
    check("ready_rel0", ready, 0);
    step();
    check("ready_rel1", ready, 0);
    step();
    check("ready_rel2", ready, 0);
    step();
    check("ready_up", ready, 1);
    check("busy_up", busy, 0);
    check("done_no_pulse", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    rst = 1'b0;
    valid = 1'b0;
    data_in = '0;
    step();
    step();
    check("rst_j", j, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    release_chk();

    send(8'h00); valid = 1'b0; wait_done(8'h00, 16);
    send(8'h90); valid = 1'b0; wait_done(8'h90, 17);
    send(8'h99); valid = 1'b0; wait_done(8'h99, 18);

    // Back-to-back with valid held: second accept lands on the done cycle.
    send(8'h09);
    a1 = acc_cyc;
    send(8'h12);
    check("b2b_on_done", done_at_acc, 1);
    check("b2b_gap", acc_cyc - a1, 17);
    valid = 1'b0;
    wait_done(8'h12, 17);

    // Reset in the middle of the payload of 0xFF.
    send(8'hFF);
    valid = 1'b0;
    repeat (7) step();
    #2;
    rst = 1'b0;
    #1;
    check("arst_j", j, 0);
    check("arst_ready", ready, 0);
    check("arst_busy", busy, 1);
    check("arst_done", done, 0);
    q.delete();
    step();
    step();
    release_chk();
    send(8'h00); valid = 1'b0; wait_done(8'h00, 16);
    repeat (4) step();

    check("det_total", det_count, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
